// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU and
// mux select codes, data-processing commands, condition mnemonics, and the
// per-state control word.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Ungated control word produced by each FSM state.
  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  // Control word for a state; unlisted fields and undefined encodings are 0.
  function automatic ctrl_t state_ctrl(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.next_pc    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_MEMADR:   c.alu_src_b = SRCB_EXTIMM;
      S_MEMREAD:  c.adr_src   = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECUTER: c.alu_op = 1'b1;
      S_EXECUTEI: begin
        c.alu_src_b = SRCB_EXTIMM;
        c.alu_op    = 1'b1;
      end
      S_ALUWB:    c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b  = SRCB_EXTIMM;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates the ARM condition field against the registered NZCV flags.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Condition table; the 1111 encoding never executes.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM with registered per-state controls,
// ALU decoder, NZCV flag register and condition gating of all writes.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int         STATE_W     = 4,
  parameter logic [3:0] FLAGS_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] RegSrc
);

  // Handshake: none. Every state lasts exactly one cycle; Cond/Op/Funct/Rd
  // come from the IR and are stable from DECODE until the next FETCH ends.

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl_q;
  logic [3:0]         flags_q;
  logic [1:0]         flag_w;
  logic               no_write;
  logic               cond_ex;
  logic               pcs;

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; the control word is registered alongside it so outputs
  // come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // ALU decode. NoWrite is taken from the instruction itself so CMP still
  // suppresses the write in ALUWB, where ALUOp is already 0.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (ctrl_q.alu_op) begin
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: ALUControl = ALU_SUB;
        default: ALUControl = ALU_ADD;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
      if (Funct[4:1] == CMD_CMP) flag_w = 2'b11;
    end
  end

  assign no_write = (Op == 2'b00) && (Funct[4:1] == CMD_CMP);

  cond_check u_cond_check (
    .cond_i    (Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // NZCV register; only executing data-processing states may update it.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAGS_RESET;
    end else if (ctrl_q.alu_op && cond_ex) begin
      if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs = ((Rd == 4'hF) & ctrl_q.reg_w) | ctrl_q.branch;

  // Architectural writes are gated by the condition and killed while in reset.
  assign PCWrite  = ~reset & (ctrl_q.next_pc | (pcs & cond_ex));
  assign RegWrite = ~reset & ctrl_q.reg_w & cond_ex & ~no_write;
  assign MemWrite = ~reset & ctrl_q.mem_w & cond_ex;
  assign IRWrite  = ~reset & ctrl_q.ir_write;

  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a driver issues instructions and
// pushes the hand-derived per-cycle controller outputs; a monitor compares
// them on every falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       adr;
    logic [1:0] res;
    logic [1:0] aluc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic [3:0] fl;
  } rec_t;

  localparam int W = $bits(rec_t);

  logic       clk;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0] result_src, alu_control, alu_src_b, imm_src, reg_src;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  multicycle_controller #(.STATE_W(4), .FLAGS_RESET(4'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (cond),
    .Op         (op),
    .Funct      (funct),
    .Rd         (rd),
    .ALUFlags   (alu_flags),
    .PCWrite    (pc_write),
    .AdrSrc     (adr_src),
    .MemWrite   (mem_write),
    .IRWrite    (ir_write),
    .ResultSrc  (result_src),
    .ALUControl (alu_control),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ImmSrc     (imm_src),
    .RegWrite   (reg_write),
    .RegSrc     (reg_src)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic set_instr(input logic [31:0] ins, input logic [3:0] af);
    cond      = ins[31:28];
    op        = ins[27:26];
    funct     = ins[25:20];
    rd        = ins[15:12];
    alu_flags = af;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_cyc(input logic [3:0] st, input logic pcw, input logic memw,
                         input logic regw, input logic irw, input logic adr,
                         input logic [1:0] res, input logic [1:0] aluc,
                         input logic srca, input logic [1:0] srcb, input logic [3:0] fl);
    rec_t r;
    r.st = st; r.pcw = pcw; r.memw = memw; r.regw = regw; r.irw = irw;
    r.adr = adr; r.res = res; r.aluc = aluc; r.srca = srca; r.srcb = srcb;
    r.imm  = op;
    r.rsrc = {op == 2'b01, op == 2'b10};
    r.fl = fl;
    exp_q.push_back(W'(r));
  endtask

  task automatic e_reset(input logic [3:0] fl);
    exp_cyc(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, fl);
  endtask
  task automatic e_fetch(input logic [3:0] fl);
    exp_cyc(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 1, 2'b10, fl);
  endtask
  task automatic e_decode(input logic [3:0] fl);
    exp_cyc(4'd1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, fl);
  endtask
  task automatic e_memadr(input logic [3:0] fl);
    exp_cyc(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, fl);
  endtask
  task automatic e_memread(input logic [3:0] fl);
    exp_cyc(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, fl);
  endtask
  task automatic e_memwb(input logic [3:0] fl, input logic regw);
    exp_cyc(4'd4, 0, 0, regw, 0, 0, 2'b01, 2'b00, 0, 2'b00, fl);
  endtask
  task automatic e_memwrite(input logic [3:0] fl, input logic memw);
    exp_cyc(4'd5, 0, memw, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, fl);
  endtask
  task automatic e_exec_r(input logic [1:0] aluc, input logic [3:0] fl);
    exp_cyc(4'd6, 0, 0, 0, 0, 0, 2'b00, aluc, 0, 2'b00, fl);
  endtask
  task automatic e_exec_i(input logic [1:0] aluc, input logic [3:0] fl);
    exp_cyc(4'd7, 0, 0, 0, 0, 0, 2'b00, aluc, 0, 2'b01, fl);
  endtask
  task automatic e_aluwb(input logic [3:0] fl, input logic regw, input logic pcw);
    exp_cyc(4'd8, pcw, 0, regw, 0, 0, 2'b00, 2'b00, 0, 2'b00, fl);
  endtask
  task automatic e_branch(input logic [3:0] fl, input logic pcw);
    exp_cyc(4'd9, pcw, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b01, fl);
  endtask
  task automatic e_unknown(input logic [3:0] fl);
    exp_cyc(4'd15, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, fl);
  endtask

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    rec_t e, a;
    cyc = cyc + 1;
    if (exp_q.size() != 0) begin
      e = rec_t'(exp_q.pop_front());
      a.st = dut.state_q; a.pcw = pc_write; a.memw = mem_write; a.regw = reg_write;
      a.irw = ir_write; a.adr = adr_src; a.res = result_src; a.aluc = alu_control;
      a.srca = alu_src_a; a.srcb = alu_src_b; a.imm = imm_src; a.rsrc = reg_src;
      a.fl = dut.flags_q;
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL cycle_%0d ctrl: got st=%0d pcw=%b memw=%b regw=%b irw=%b adr=%b res=%b aluc=%b a=%b b=%b imm=%b rsrc=%b fl=%b, want st=%0d pcw=%b memw=%b regw=%b irw=%b adr=%b res=%b aluc=%b a=%b b=%b imm=%b rsrc=%b fl=%b",
                 cyc, a.st, a.pcw, a.memw, a.regw, a.irw, a.adr, a.res, a.aluc, a.srca, a.srcb, a.imm, a.rsrc, a.fl,
                 e.st, e.pcw, e.memw, e.regw, e.irw, e.adr, e.res, e.aluc, e.srca, e.srcb, e.imm, e.rsrc, e.fl);
      end
    end
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    set_instr(32'h0000_0000, 4'h0);
    @(posedge clk);
    #1;
    e_reset(4'h0);
    e_reset(4'h0);
    step(2);
    reset = 1'b0;

    // ADD R2,R0,#5
    set_instr(32'hE280_2005, 4'hF);
    e_fetch(4'h0); e_decode(4'h0); e_exec_i(2'b00, 4'h0); e_aluwb(4'h0, 1, 0);
    step(4);

    // ADD PC,PC,#4: register write to R15 also writes the PC
    set_instr(32'hE28F_F004, 4'h0);
    e_fetch(4'h0); e_decode(4'h0); e_exec_i(2'b00, 4'h0); e_aluwb(4'h0, 1, 1);
    step(4);

    // CMP R0,#0 with Z result
    set_instr(32'hE350_0000, 4'b0100);
    e_fetch(4'h0); e_decode(4'h0); e_exec_i(2'b01, 4'h0); e_aluwb(4'b0100, 0, 0);
    step(4);

    // BEQ taken
    set_instr(32'h0A00_0001, 4'h0);
    e_fetch(4'b0100); e_decode(4'b0100); e_branch(4'b0100, 1);
    step(3);

    // BNE not taken
    set_instr(32'h1A00_0001, 4'h0);
    e_fetch(4'b0100); e_decode(4'b0100); e_branch(4'b0100, 0);
    step(3);

    // CMP clearing all flags
    set_instr(32'hE350_0000, 4'b0000);
    e_fetch(4'b0100); e_decode(4'b0100); e_exec_i(2'b01, 4'b0100); e_aluwb(4'h0, 0, 0);
    step(4);

    // STREQ with Z=0: full path, no write
    set_instr(32'h0580_1000, 4'h0);
    e_fetch(4'h0); e_decode(4'h0); e_memadr(4'h0); e_memwrite(4'h0, 0);
    step(4);

    // LDR R1,[R0,#4]
    set_instr(32'hE590_1004, 4'h0);
    e_fetch(4'h0); e_decode(4'h0); e_memadr(4'h0); e_memread(4'h0); e_memwb(4'h0, 1);
    step(5);

    // STR
    set_instr(32'hE580_1080, 4'h0);
    e_fetch(4'h0); e_decode(4'h0); e_memadr(4'h0); e_memwrite(4'h0, 1);
    step(4);

    // ANDS R2,R1,R3: only N,Z are updated
    set_instr(32'hE011_2003, 4'hF);
    e_fetch(4'h0); e_decode(4'h0); e_exec_r(2'b10, 4'h0); e_aluwb(4'b1100, 1, 0);
    step(4);

    // ORRNE with Z=1: condition fails, no register write
    set_instr(32'h1181_2003, 4'h0);
    e_fetch(4'b1100); e_decode(4'b1100); e_exec_r(2'b11, 4'b1100); e_aluwb(4'b1100, 0, 0);
    step(4);

    // SUBSNE with Z=1: flags must not change
    set_instr(32'h1051_2003, 4'b0011);
    e_fetch(4'b1100); e_decode(4'b1100); e_exec_r(2'b01, 4'b1100); e_aluwb(4'b1100, 0, 0);
    step(4);

    // Illegal Op=11
    set_instr(32'hEC00_0000, 4'h0);
    e_fetch(4'b1100); e_decode(4'b1100); e_unknown(4'b1100);
    step(3);

    // CMP loading non-reset flags
    set_instr(32'hE350_0000, 4'b1011);
    e_fetch(4'b1100); e_decode(4'b1100); e_exec_i(2'b01, 4'b1100); e_aluwb(4'b1011, 0, 0);
    step(4);

    // LDR abandoned by reset in MEMREAD
    set_instr(32'hE590_1004, 4'h0);
    e_fetch(4'b1011); e_decode(4'b1011); e_memadr(4'b1011); e_memread(4'b1011);
    e_reset(4'h0);
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    // Restart after reset
    set_instr(32'hE280_2005, 4'h0);
    e_fetch(4'h0); e_decode(4'h0); e_exec_i(2'b00, 4'h0); e_aluwb(4'h0, 1, 0);
    step(4);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
